// File: rtl/decode_out_buf_pkg.sv
// Shared types and defaults for the decode-to-execute elastic buffer.
// The sizes here are the defaults used for the buffer's parameters.
package decode_out_buf_pkg;

  localparam int unsigned INSN_W_DEF   = 16;
  localparam int unsigned E_CTRL_W_DEF = 6;
  localparam int unsigned W_CTRL_W_DEF = 2;
  localparam int unsigned DEPTH_DEF    = 2;

  typedef struct packed {
    logic [INSN_W_DEF-1:0]   IR;
    logic [INSN_W_DEF-1:0]   npc;
    logic [E_CTRL_W_DEF-1:0] E_Control;
    logic [W_CTRL_W_DEF-1:0] W_Control;
    logic                    Mem_Control;
  } decode_bundle_t;

  localparam decode_bundle_t DECODE_NOP = '0;

endpackage

// File: rtl/decode_out_buf_if.sv
// Handshake/bundle signals between decode, the buffer and execute.
// master: decode/execute side; slave: the buffer itself.
interface decode_out_buf_if #(
  parameter int unsigned INSN_W   = 16,
  parameter int unsigned E_CTRL_W = 6,
  parameter int unsigned W_CTRL_W = 2,
  parameter int unsigned DEPTH    = 2
);

  logic                        in_valid;
  logic                        in_ready;
  logic [INSN_W-1:0]           IR_in;
  logic [INSN_W-1:0]           npc_in;
  logic [E_CTRL_W-1:0]         E_Control_in;
  logic [W_CTRL_W-1:0]         W_Control_in;
  logic                        Mem_Control_in;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [INSN_W-1:0]           IR;
  logic [INSN_W-1:0]           npc_out;
  logic [E_CTRL_W-1:0]         E_Control;
  logic [W_CTRL_W-1:0]         W_Control;
  logic                        Mem_Control;
  logic [$clog2(DEPTH+1)-1:0]  count;

  modport master (
    output in_valid, IR_in, npc_in, E_Control_in, W_Control_in, Mem_Control_in,
    output flush, out_ready,
    input  in_ready, out_valid, IR, npc_out, E_Control, W_Control, Mem_Control, count
  );

  modport slave (
    input  in_valid, IR_in, npc_in, E_Control_in, W_Control_in, Mem_Control_in,
    input  flush, out_ready,
    output in_ready, out_valid, IR, npc_out, E_Control, W_Control, Mem_Control, count
  );

endinterface

// File: rtl/decode_out_buf_ctrl.sv
// Pointer/occupancy control for decode_out_buf.
// DECODE_OUT_BUF_BYPASS_EN enables zero-cycle fall-through when empty.
module decode_out_buf_ctrl #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic                       push,
  output logic                       bypass_fwd,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [$clog2(DEPTH)-1:0]   wr_ptr,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty;
  logic             bypass_hit;
  logic             pop;

  always_comb begin
    empty    = (count_q == '0);
    in_ready = (count_q != CNT_W'(DEPTH));
`ifdef DECODE_OUT_BUF_BYPASS_EN
    bypass_hit = empty & in_valid & out_ready;
    bypass_fwd = bypass_hit & ~flush;
`else
    bypass_hit = 1'b0;
    bypass_fwd = 1'b0;
`endif
    out_valid = ~empty | bypass_fwd;
    // A forwarded bundle is consumed directly and never occupies an entry.
    push      = in_valid & in_ready & ~bypass_hit & ~flush;
    pop       = ~empty & out_ready;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/decode_out_buf.sv
// Elastic FIFO between LC3 decode and execute with synchronous flush.
// Optional fall-through controlled by DECODE_OUT_BUF_BYPASS_EN (see ctrl).
module decode_out_buf
  import decode_out_buf_pkg::*;
#(
  parameter int unsigned INSN_W   = INSN_W_DEF,
  parameter int unsigned E_CTRL_W = E_CTRL_W_DEF,
  parameter int unsigned W_CTRL_W = W_CTRL_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  decode_out_buf_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSN_W-1:0]   IR;
    logic [INSN_W-1:0]   npc;
    logic [E_CTRL_W-1:0] E_Control;
    logic [W_CTRL_W-1:0] W_Control;
    logic                Mem_Control;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           in_entry;
  entry_t           out_entry;
  logic             push;
  logic             bypass_fwd;
  logic             in_ready;
  logic             out_valid;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  decode_out_buf_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (bus.in_valid),
    .out_ready  (bus.out_ready),
    .flush      (bus.flush),
    .push       (push),
    .bypass_fwd (bypass_fwd),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .count      (count)
  );

  always_comb begin
    in_entry.IR          = bus.IR_in;
    in_entry.npc         = bus.npc_in;
    in_entry.E_Control   = bus.E_Control_in;
    in_entry.W_Control   = bus.W_Control_in;
    in_entry.Mem_Control = bus.Mem_Control_in;
  end

  // Storage is deliberately not reset; emptiness alone selects the NOP bundle.
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = in_entry;
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    out_entry = '0;
    if (bypass_fwd)        out_entry = in_entry;
    else if (count != '0)  out_entry = mem_q[rd_ptr];
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.count       = count;
  assign bus.IR          = out_entry.IR;
  assign bus.npc_out     = out_entry.npc;
  assign bus.E_Control   = out_entry.E_Control;
  assign bus.W_Control   = out_entry.W_Control;
  assign bus.Mem_Control = out_entry.Mem_Control;

endmodule

// File: tb/tb_decode_out_buf.sv
// Directed self-checking bench for decode_out_buf (DEPTH=2).
// Expectations follow DECODE_OUT_BUF_BYPASS_EN when it is defined.
module tb_decode_out_buf;
  import decode_out_buf_pkg::*;

  logic clock;
  logic reset;
  int   vectors;
  int   miscompares;

  decode_out_buf_if #(.INSN_W(16), .E_CTRL_W(6), .W_CTRL_W(2), .DEPTH(2)) bus ();

  decode_out_buf #(.INSN_W(16), .E_CTRL_W(6), .W_CTRL_W(2), .DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic decode_bundle_t mk(input logic [15:0] ir);
    decode_bundle_t b;
    b.IR          = ir;
    b.npc         = ir + 16'h0001;
    b.E_Control   = ir[5:0] ^ 6'h15;
    b.W_Control   = ir[1:0];
    b.Mem_Control = ir[2];
    return b;
  endfunction

  function automatic decode_bundle_t observed();
    decode_bundle_t b;
    b.IR          = bus.IR;
    b.npc         = bus.npc_out;
    b.E_Control   = bus.E_Control;
    b.W_Control   = bus.W_Control;
    b.Mem_Control = bus.Mem_Control;
    return b;
  endfunction

  task automatic drive(input logic v, input decode_bundle_t b);
    bus.in_valid       = v;
    bus.IR_in          = b.IR;
    bus.npc_in         = b.npc;
    bus.E_Control_in   = b.E_Control;
    bus.W_Control_in   = b.W_Control;
    bus.Mem_Control_in = b.Mem_Control;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, DECODE_NOP);
    tick();
    tick();
    reset = 1'b1;
    tick();
    vectors++;
    if (bus.count !== 2'd0) begin
      miscompares++; $display("FAIL reset_count got %0d exp 0", bus.count);
    end
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready);
    end
    vectors++;
    if (bus.IR !== 16'h0000) begin
      miscompares++; $display("FAIL reset_IR got %h exp 0000", bus.IR);
    end
  endtask

  task automatic test_single_push();
    decode_bundle_t b;
    b.IR = 16'h1234; b.npc = 16'h3001; b.E_Control = 6'h2A;
    b.W_Control = 2'b01; b.Mem_Control = 1'b1;
    bus.out_ready = 1'b0;
    drive(1'b1, b);
    tick();
    drive(1'b0, DECODE_NOP);
    #1;
    vectors++;
    if (observed() !== b) begin
      miscompares++; $display("FAIL single_bundle got %h exp %h", observed(), b);
    end
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.count !== 2'd1) begin
      miscompares++;
      $display("FAIL single_state got valid=%b count=%0d exp valid=1 count=1", bus.out_valid, bus.count);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 2'd0 || observed() !== DECODE_NOP) begin
      miscompares++;
      $display("FAIL single_drain got count=%0d bundle=%h exp count=0 bundle=0", bus.count, observed());
    end
  endtask

  task automatic test_back_to_back();
    decode_bundle_t a, b, c;
    a = mk(16'h1001); b = mk(16'h1002); c = mk(16'h1003);
    bus.out_ready = 1'b0;
    drive(1'b1, a);
    tick();
    drive(1'b1, b);
    tick();
    drive(1'b1, c);
    #1;
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.count !== 2'd2) begin
      miscompares++;
      $display("FAIL full_state got in_ready=%b count=%0d exp 0/2", bus.in_ready, bus.count);
    end
    tick();
    vectors++;
    if (bus.count !== 2'd2 || observed() !== a) begin
      miscompares++;
      $display("FAIL held_off got count=%0d head=%h exp count=2 head=%h", bus.count, observed(), a);
    end
    bus.out_ready = 1'b1;
    tick();
    #1;
    vectors++;
    if (bus.count !== 2'd1 || observed() !== b || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL first_pop got count=%0d head=%h rdy=%b exp 1/%h/1", bus.count, observed(), bus.in_ready, b);
    end
    tick();
    drive(1'b0, DECODE_NOP);
    #1;
    vectors++;
    if (bus.count !== 2'd1 || observed() !== c) begin
      miscompares++;
      $display("FAIL third_accept got count=%0d head=%h exp 1/%h", bus.count, observed(), c);
    end
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL drained got count=%0d valid=%b exp 0/0", bus.count, bus.out_valid);
    end
  endtask

  task automatic test_stream();
    decode_bundle_t e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      e = mk(16'h2000 + 16'(i));
      drive(1'b1, e);
      #1;
`ifdef DECODE_OUT_BUF_BYPASS_EN
      vectors++;
      if (observed() !== e || bus.count !== 2'd0 || bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_%0d got %h count=%0d valid=%b exp %h count=0", i, observed(), bus.count, bus.out_valid, e);
      end
      tick();
`else
      tick();
      vectors++;
      if (observed() !== e || bus.count !== 2'd1 || bus.out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_%0d got %h count=%0d valid=%b exp %h count=1", i, observed(), bus.count, bus.out_valid, e);
      end
`endif
    end
    drive(1'b0, DECODE_NOP);
    tick();
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 2'd0) begin
      miscompares++; $display("FAIL stream_end_count got %0d exp 0", bus.count);
    end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, mk(16'h3001));
    tick();
    drive(1'b1, mk(16'h3002));
    tick();
    vectors++;
    if (bus.count !== 2'd2) begin
      miscompares++; $display("FAIL flush_pre_count got %0d exp 2", bus.count);
    end
    drive(1'b1, mk(16'hDEAD));
    bus.flush = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, DECODE_NOP);
    #1;
    vectors++;
    if (bus.count !== 2'd0 || bus.out_valid !== 1'b0 || observed() !== DECODE_NOP) begin
      miscompares++;
      $display("FAIL flush_clear got count=%0d valid=%b bundle=%h exp 0/0/0", bus.count, bus.out_valid, observed());
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (bus.out_valid !== 1'b0) begin
        miscompares++; $display("FAIL flush_no_emit_%0d got valid=%b exp 0", i, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    drive(1'b1, mk(16'h3003));
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, DECODE_NOP);
    vectors++;
    if (bus.count !== 2'd0) begin
      miscompares++; $display("FAIL flush_push_discard got count=%0d exp 0", bus.count);
    end
    drive(1'b1, mk(16'h3004));
    tick();
    drive(1'b0, DECODE_NOP);
    vectors++;
    if (bus.count !== 2'd1) begin
      miscompares++; $display("FAIL midop_pre_count got %0d exp 1", bus.count);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    vectors++;
    if (bus.count !== 2'd0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset got count=%0d rdy=%b valid=%b exp 0/1/0", bus.count, bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_bypass();
    decode_bundle_t b;
    b = mk(16'hABCD);
    bus.out_ready = 1'b1;
    drive(1'b1, b);
    #1;
`ifdef DECODE_OUT_BUF_BYPASS_EN
    vectors++;
    if (bus.IR !== 16'hABCD || bus.out_valid !== 1'b1 || bus.count !== 2'd0) begin
      miscompares++;
      $display("FAIL bypass_same_cycle got IR=%h valid=%b count=%0d exp ABCD/1/0", bus.IR, bus.out_valid, bus.count);
    end
    tick();
    drive(1'b0, DECODE_NOP);
    vectors++;
    if (bus.count !== 2'd0) begin
      miscompares++; $display("FAIL bypass_not_stored got count=%0d exp 0", bus.count);
    end
`else
    vectors++;
    if (bus.IR !== 16'h0000 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL nobypass_same_cycle got IR=%h valid=%b exp 0000/0", bus.IR, bus.out_valid);
    end
    tick();
    drive(1'b0, DECODE_NOP);
    #1;
    vectors++;
    if (bus.IR !== 16'hABCD || bus.out_valid !== 1'b1 || bus.count !== 2'd1) begin
      miscompares++;
      $display("FAIL nobypass_next_cycle got IR=%h valid=%b count=%0d exp ABCD/1/1", bus.IR, bus.out_valid, bus.count);
    end
    tick();
`endif
    drive(1'b1, mk(16'h4242));
    bus.flush = 1'b1;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || observed() !== DECODE_NOP) begin
      miscompares++;
      $display("FAIL bypass_flush got valid=%b bundle=%h exp 0/0", bus.out_valid, observed());
    end
    tick();
    bus.flush = 1'b0;
    drive(1'b0, DECODE_NOP);
    bus.out_ready = 1'b0;
    vectors++;
    if (bus.count !== 2'd0) begin
      miscompares++; $display("FAIL bypass_flush_count got %0d exp 0", bus.count);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_push();
    test_back_to_back();
    test_stream();
    test_flush();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/decode_out_buf.md
# decode_out_buf

Parametrised elastic buffer between the LC3 decode stage and execute. It carries the decode output bundle (IR, npc_out, E_Control, W_Control, Mem_Control) through a DEPTH-entry FIFO with valid/ready handshakes on both sides and a synchronous flush. This lets decode run ahead of a stalled execute stage and discard wrong-path instructions on a branch redirect.

## Interface
- INSN_W, 16, width of IR and npc fields
- E_CTRL_W, 6, width of E_Control
- W_CTRL_W, 2, width of W_Control
- DEPTH, 2, number of entries; power of two, ≥2
- clock  input  1  single clock; all state updates on rising edge
- reset  input  1  synchronous, active-low; sampled on the rising edge of clock
- in_valid  input  1  decode presents a bundle
- in_ready  output  1  buffer accepts the bundle this cycle
- IR_in, npc_in  input  INSN_W each  incoming instruction and next PC
- E_Control_in / W_Control_in / Mem_Control_in  input  E_CTRL_W / W_CTRL_W / 1  incoming controls
- flush  input  1  discard all stored entries
- out_valid  output  1  head bundle valid
- out_ready  input  1  execute consumes the head bundle
- IR, npc_out  output  INSN_W each  head instruction and next PC
- E_Control / W_Control / Mem_Control  output  E_CTRL_W / W_CTRL_W / 1  head controls
- count  output  $clog2(DEPTH+1)  number of occupied entries

## Operation
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so there is no push-through when full.
- out_valid = (count != 0).
- Outputs show the head entry. When the buffer is empty, outputs drive the NOP bundle (all fields zero).
- Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally. count updates +1 on push only, −1 on pop only, and is unchanged on simultaneous push and pop.
- Push and pop in the same cycle are legal at any occupancy from 1 to DEPTH−1.
- flush has priority over everything:
  - pointers and count clear at the edge;
  - a push in the same cycle is discarded;
  - a pop in the same cycle is still considered taken by the consumer.
- Reset (reset==0 at an edge) has the same effect as flush and is valid mid-operation.
  - After reset: count=0, out_valid=0, in_ready=1, IR/npc_out/E_Control/W_Control/Mem_Control all 0.
- Storage contents are not cleared by flush or reset. The NOP output is produced from the empty condition.

## Timing
- Without bypass, latency is 1 cycle: a bundle pushed at edge N is visible on the outputs with out_valid=1 from edge N to edge N+1.
- Throughput is one bundle per cycle sustained when out_ready=1.
- in_ready deasserts the cycle after the push that fills the buffer. It reasserts the cycle after the first pop from full.
- Flush asserted during cycle N gives out_valid=0 and count=0 from edge N onward.

## Configuration
- Macro: DECODE_OUT_BUF_BYPASS_EN.
- Defined: when count==0, in_valid=1 and out_ready=1, the input bundle is forwarded combinationally to the outputs with out_valid=1. The bundle is not stored and count stays 0 (zero-cycle fall-through).
  - flush in that cycle suppresses the forward: out_valid=0 and the NOP bundle is driven.
- Undefined: no combinational in-to-out path, and latency is always 1 cycle.

## Structure
- Package decode_out_buf_pkg holds:
  - typedef struct packed decode_bundle_t {IR, npc, E_Control, W_Control, Mem_Control}, sized by the package defaults;
  - localparam DECODE_NOP, the all-zero bundle.
- One sub-module, decode_out_buf_ctrl, holds the pointers, count, in_ready and out_valid. The top level holds the storage array and the output mux.

## Test plan
- Reset then idle → count=0, out_valid=0, in_ready=1, IR=16'h0000.
- Push IR=16'h1234, npc=16'h3001, E_Control=6'h2A, W_Control=2'b01, Mem_Control=1 with out_ready=0 → the next cycle shows those exact values with out_valid=1 and count=1.
- DEPTH=2: push three bundles back-to-back with out_ready=0.
  - Expect in_ready=0 after the second push.
  - The third is held off and count=2.
  - Set out_ready=1: bundles drain in order and the third is accepted the cycle after the first pop.
- Stream 8 bundles with out_ready=1 throughout → one bundle out per cycle, in order, pointers wrap, count never exceeds 1.
- count=2 and flush=1 with in_valid=1 in the same cycle → next cycle count=0, out_valid=0, outputs all zero, and the pushed bundle is never emitted.
- With DECODE_OUT_BUF_BYPASS_EN: empty buffer, in_valid=1, out_ready=1, IR=16'hABCD → IR=16'hABCD and out_valid=1 in the same cycle, count stays 0. Without the macro, IR=16'hABCD appears one cycle later.
